// File: rtl/riscv_trace_pkg.sv
// Shared constants for the retirement trace buffer: FSM encoding, capture modes
// and the width of one stored {ts, pc, ins} entry.
package riscv_trace_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPTURE = 3'd1;
  localparam logic [2:0] ST_POST    = 3'd2;
  localparam logic [2:0] ST_FROZEN  = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;

  localparam logic MODE_WRAP      = 1'b0;
  localparam logic MODE_STOP_FULL = 1'b1;

  function automatic int entry_w(input int ts_w, input int xlen, input int ilen);
    return ts_w + xlen + ilen;
  endfunction

endpackage

// File: rtl/riscv_trace_ram.sv
// Trace storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module riscv_trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 80,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/riscv_trace_buffer.sv
// Retirement trace buffer: captures {ts, pc, ins} into a circular RAM, freezes on
// stop/trigger/full, then drains oldest-first over a valid/ready stream.
module riscv_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 16,
  parameter int TS_W  = 16,
  parameter int DEDUP = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arm,
  input  logic                      mode,
  input  logic                      trig_en,
  input  logic [XLEN-1:0]           trig_pc,
  input  logic [$clog2(DEPTH):0]    post_cnt,
  input  logic                      ret_valid,
  input  logic [XLEN-1:0]           pc_i,
  input  logic [ILEN-1:0]           ins_i,
  input  logic                      rd_start,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [TS_W+XLEN+ILEN-1:0] rd_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      trig_hit,
  output logic [2:0]                state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = entry_w(TS_W, XLEN, ILEN);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [2:0]      st;
  logic [AW-1:0]   wr_ptr, rd_ptr, raddr;
  logic [CW-1:0]   cnt, rem;
  logic [TS_W-1:0] ts;
  logic [XLEN-1:0] last_pc;
  logic            first, hit;
  logic [EW-1:0]   rdata;
  logic            capturing, wr_en, trig, full_stop, rd_xfer;

  assign capturing = (st == ST_CAPTURE) || (st == ST_POST);
  assign wr_en     = capturing && ret_valid && ((DEDUP == 0) || first || (pc_i != last_pc));
  // Trigger looks at the raw retire, so a deduplicated PC can still fire it.
  assign trig      = (st == ST_CAPTURE) && trig_en && ret_valid && (pc_i == trig_pc);
  assign full_stop = (mode == MODE_STOP_FULL) && wr_en && (cnt == FULL - CW'(1));
  assign rd_xfer   = rd_valid && rd_ready;

  // In FROZEN the port fetches the oldest entry; in DRAIN it prefetches the next.
  assign raddr = (st == ST_FROZEN) ? ((cnt == FULL) ? wr_ptr : '0) : rd_ptr + AW'(1);

  riscv_trace_ram #(.DEPTH(DEPTH), .W(EW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({ts, pc_i, ins_i}),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      st       <= ST_IDLE;
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ts       <= '0;
      hit      <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      first    <= 1'b0;
      last_pc  <= '0;
      rem      <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (arm) begin
            st     <= ST_CAPTURE;
            wr_ptr <= '0;
            cnt    <= '0;
            ts     <= '0;
            hit    <= 1'b0;
            first  <= 1'b1;
          end
        end

        ST_CAPTURE, ST_POST: begin
          ts <= ts + TS_W'(1);
          if (wr_en) begin
            wr_ptr  <= wr_ptr + AW'(1);
            if (cnt != FULL) cnt <= cnt + CW'(1);
            last_pc <= pc_i;
            first   <= 1'b0;
          end
          if (trig) hit <= 1'b1;
          // Full and manual stop take priority over trigger/post-window progress.
          if (full_stop || !arm) begin
            st <= ST_FROZEN;
          end else if (st == ST_POST) begin
            if (wr_en) begin
              rem <= rem - CW'(1);
              if (rem == CW'(1)) st <= ST_FROZEN;
            end
          end else if (trig) begin
            if (post_cnt == '0) begin
              st <= ST_FROZEN;
            end else begin
              st  <= ST_POST;
              rem <= post_cnt;
            end
          end
        end

        ST_FROZEN: begin
          if (rd_start) begin
            if (cnt == '0) begin
              st <= ST_IDLE;
            end else begin
              st       <= ST_DRAIN;
              rd_ptr   <= raddr;
              rem      <= cnt;
              rd_data  <= rdata;
              rd_valid <= 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          if (rd_xfer) begin
            if (rem == CW'(1)) begin
              rd_valid <= 1'b0;
              cnt      <= '0;
              st       <= ST_IDLE;
            end else begin
              rd_ptr  <= raddr;
              rd_data <= rdata;
              rem     <= rem - CW'(1);
            end
          end
        end

        default: st <= ST_IDLE;
      endcase
    end
  end

  assign count    = cnt;
  assign trig_hit = hit;
  assign state    = st;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Randomized scoreboard bench for riscv_trace_buffer (DEPTH=8, DEDUP=1): a list-based
// capture model queues expected entries, a negedge monitor checks every drained beat.
module tb_riscv_trace_buffer;
  import riscv_trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int TS_W  = 16;

  logic        clk = 1'b0, reset = 1'b0;
  logic        arm = 1'b0, mode = 1'b0, trig_en = 1'b0, ret_valid = 1'b0;
  logic        rd_start = 1'b0, rd_ready = 1'b0;
  logic [31:0] trig_pc = '0, pc_i = '0, ins_i = '0;
  logic [3:0]  post_cnt = '0;
  logic        rd_valid, trig_hit;
  logic [79:0] rd_data;
  logic [3:0]  count;
  logic [2:0]  state;

  int          checks = 0, failures = 0, xfers = 0;
  logic [79:0] expq[$];

  always #5 clk = ~clk;

  riscv_trace_buffer #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .TS_W(TS_W), .DEDUP(1)) dut (
    .clk(clk), .reset(reset), .arm(arm), .mode(mode), .trig_en(trig_en), .trig_pc(trig_pc),
    .post_cnt(post_cnt), .ret_valid(ret_valid), .pc_i(pc_i), .ins_i(ins_i),
    .rd_start(rd_start), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .trig_hit(trig_hit), .state(state)
  );

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset && rd_valid && rd_ready) begin
      if (expq.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_unexpected act=%0h exp=none", rd_data);
      end else begin
        chk("rd_data", rd_data, expq.pop_front());
      end
      xfers++;
    end
  end

  // Model: entries are kept as a plain list of what was recorded; the capture
  // window closes on stop-full, trigger+post window, or arm drop.
  task automatic run_capture(input bit md, input bit te, input logic [31:0] tpc, input int pst,
                             input logic [31:0] pcs[$], input bit rvs[$]);
    logic [79:0] rec[$];
    bit          cap = 1, first = 1, hit = 0, w, tg;
    int          post = -1;
    logic [31:0] lastpc = '0, ins;
    mode = md; trig_en = te; trig_pc = tpc; post_cnt = 4'(pst);
    arm = 1; ret_valid = 0;
    tick();
    for (int i = 0; i < pcs.size(); i++) begin
      ins = $urandom;
      pc_i = pcs[i]; ins_i = ins; ret_valid = rvs[i];
      if (cap) begin
        w  = rvs[i] && (first || pcs[i] != lastpc);
        tg = (post < 0) && te && rvs[i] && (pcs[i] == tpc);
        if (w) begin
          rec.push_back({16'(i), pcs[i], ins});
          if (rec.size() > DEPTH) void'(rec.pop_front());
          first = 0; lastpc = pcs[i];
        end
        if (tg) hit = 1;
        if (md && w && rec.size() == DEPTH) cap = 0;
        else if (post > 0) begin
          if (w) begin post--; if (post == 0) cap = 0; end
        end else if (tg) begin
          if (pst == 0) cap = 0; else post = pst;
        end
      end
      tick();
    end
    chk("state_after_stim", 80'(state), 80'(cap ? ((post > 0) ? ST_POST : ST_CAPTURE) : ST_FROZEN));
    arm = 0; ret_valid = 0;
    tick();
    chk("state_frozen", 80'(state), 80'(ST_FROZEN));
    chk("count", 80'(count), 80'(rec.size()));
    chk("trig_hit", 80'(trig_hit), 80'(hit));
    foreach (rec[k]) expq.push_back(rec[k]);
  endtask

  task automatic drain(input bit rnd, input int hold);
    int x0;
    rd_ready = (hold > 0) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    rd_start = 1;
    tick();
    rd_start = 0;
    if (hold > 0 && expq.size() > 0) begin
      for (int c = 0; c < hold; c++) begin
        chk("bp_valid", 80'(rd_valid), 80'(1));
        chk("bp_data", rd_data, expq[0]);
        tick();
      end
      x0 = xfers;
      rd_ready = 1;
      tick();
      chk("bp_xfer", 80'(xfers - x0), 80'(1));
    end
    for (int c = 0; ; c++) begin
      if (expq.size() == 0) break;
      if (c == 300) begin
        checks++; failures++;
        $display("FAIL drain_timeout act=%0d left exp=0", expq.size());
        expq.delete();
        break;
      end
      tick();
      if (rnd) rd_ready = 1'($urandom_range(0, 1));
    end
    rd_ready = 0;
    chk("drain_idle", 80'(state), 80'(ST_IDLE));
    chk("drain_count", 80'(count), 80'(0));
    chk("drain_valid", 80'(rd_valid), 80'(0));
  endtask

  initial begin
    logic [31:0] pcs[$];
    bit          rvs[$];
    int          x0;

    // Reset with random inputs
    reset = 0;
    for (int c = 0; c < 2; c++) begin
      arm = 1'($urandom); mode = 1'($urandom); trig_en = 1'($urandom); ret_valid = 1'($urandom);
      rd_start = 1'($urandom); rd_ready = 1'($urandom); pc_i = $urandom; ins_i = $urandom;
      tick();
    end
    chk("rst_state", 80'(state), 80'(ST_IDLE));
    chk("rst_count", 80'(count), 80'(0));
    chk("rst_valid", 80'(rd_valid), 80'(0));
    chk("rst_data", rd_data, 80'(0));
    chk("rst_trig", 80'(trig_hit), 80'(0));
    arm = 0; rd_start = 0; rd_ready = 0; ret_valid = 0;
    reset = 1;
    tick();

    for (int i = 0; i < 10; i++) begin pcs.push_back(32'(4 * i)); rvs.push_back(1'b1); end
    run_capture(MODE_WRAP, 0, '0, 0, pcs, rvs);          // wrap: keeps 0x08..0x24
    drain(1, 0);
    run_capture(MODE_STOP_FULL, 0, '0, 0, pcs, rvs);     // stop-full after 0x1C
    drain(1, 0);
    run_capture(MODE_WRAP, 1, 32'h10, 2, pcs, rvs);      // trigger, frozen after 0x18
    drain(1, 0);

    pcs.delete(); rvs.delete();
    for (int i = 0; i < 5; i++) begin pcs.push_back(32'h40); rvs.push_back(1'b1); end
    run_capture(MODE_WRAP, 0, '0, 0, pcs, rvs);          // dedup -> one entry
    drain(0, 3);

    for (int t = 0; t < 25; t++) begin
      pcs.delete(); rvs.delete();
      for (int i = 0; i < $urandom_range(4, 24); i++) begin
        pcs.push_back(32'h100 + 32'(4 * $urandom_range(0, 3)));
        rvs.push_back($urandom_range(0, 3) != 0);
      end
      run_capture(1'($urandom), 1'($urandom), 32'h100 + 32'(4 * $urandom_range(0, 3)),
                  $urandom_range(0, 9), pcs, rvs);
      drain(1, 0);
    end

    // Reset in the middle of a 6-entry drain
    pcs.delete(); rvs.delete();
    for (int i = 0; i < 6; i++) begin pcs.push_back(32'h200 + 32'(4 * i)); rvs.push_back(1'b1); end
    run_capture(MODE_WRAP, 0, '0, 0, pcs, rvs);
    x0 = xfers;
    rd_ready = 1; rd_start = 1;
    tick();
    rd_start = 0;
    for (int c = 0; c < 50; c++) begin
      if (xfers - x0 >= 2) break;
      tick();
    end
    chk("mid_xfers", 80'(xfers - x0), 80'(2));
    reset = 0; rd_ready = 0;
    tick();
    chk("mid_rst_state", 80'(state), 80'(ST_IDLE));
    chk("mid_rst_valid", 80'(rd_valid), 80'(0));
    chk("mid_rst_count", 80'(count), 80'(0));
    expq.delete();
    reset = 1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_trace_buffer.md
Name: riscv_trace_buffer

Overview:
- Synthesizable on-chip retirement trace for riscv_top. Records {timestamp, PC, instruction} of retired instructions into a circular buffer.
- Capture stops on manual stop, on a PC-match trigger after a programmable post-trigger window, or when the buffer is full (stop-full mode).
- The frozen buffer drains oldest-first over a valid/ready stream, so benches and on-chip debug read a trace instead of relying on simulation-only monitors.

Parameters:
- XLEN, 32, PC width
- ILEN, 32, instruction width
- DEPTH, 16, entries; power of two, at least 2
- TS_W, 16, timestamp width; wraps modulo 2^TS_W
- DEDUP, 1, when 1, a retire with pc_i equal to the last written PC is not recorded

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low (0 = reset)
- arm  in  1  level; 1 starts/holds capture, 0 stops it
- mode  in  1  0 = wrap (continuous), 1 = stop-full
- trig_en  in  1  enable PC trigger
- trig_pc  in  XLEN  trigger address
- post_cnt  in  $clog2(DEPTH)+1  entries recorded after the trigger entry
- ret_valid  in  1  instruction retired this cycle
- pc_i  in  XLEN  retired PC
- ins_i  in  ILEN  retired instruction
- rd_start  in  1  pulse; begin drain when frozen
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts
- rd_data  out  TS_W+XLEN+ILEN  {ts, pc, ins}
- count  out  $clog2(DEPTH)+1  entries held
- trig_hit  out  1  trigger fired in current capture
- state  out  3  IDLE/CAPTURE/POST/FROZEN/DRAIN

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE; count, wr_ptr, rd_ptr, ts, trig_hit, rd_valid, rd_data all 0. RAM contents are not reset. Reset overrides every other input and applies mid-capture or mid-drain; rd_valid is 0 from the next cycle.
- IDLE:
  - arm=1 -> CAPTURE. Clear wr_ptr, count, ts and trig_hit. Set first=1.
- CAPTURE/POST, each cycle:
  - ts increments.
  - A write occurs when ret_valid=1 and (DEDUP=0 or first=1 or pc_i != last_pc).
  - A write stores {ts, pc_i, ins_i} at wr_ptr and advances wr_ptr modulo DEPTH.
  - count increments, saturating at DEPTH. last_pc is updated and first is cleared.
- Trigger:
  - Fires in CAPTURE when trig_en, ret_valid and pc_i==trig_pc, independent of dedup suppression. Sets trig_hit=1.
  - post_cnt==0 -> FROZEN next cycle.
  - Otherwise -> POST with remaining=post_cnt. Each write in POST decrements remaining; the write that brings it to 0 -> FROZEN.
  - Triggers in POST are ignored.
- Stop-full: with mode=1, the write that makes count==DEPTH -> FROZEN, in either CAPTURE or POST. A trigger on that same write also sets trig_hit, and full wins.
- Wrap mode: overwrites the oldest entry; count stays DEPTH.
- arm=0 in CAPTURE/POST -> FROZEN. A same-cycle write still occurs.
- FROZEN:
  - Holds contents; arm is ignored.
  - rd_start with count==0 -> IDLE.
  - rd_start otherwise -> DRAIN, with rd_ptr = (count==DEPTH) ? wr_ptr : 0 and remaining = count.
- DRAIN:
  - rd_valid rises 1 cycle after rd_start, with rd_data registered from the RAM at rd_ptr.
  - A transfer happens when rd_valid&rd_ready: rd_ptr advances, remaining decrements, and the next entry loads the same cycle.
  - rd_data and rd_valid are stable while rd_valid&!rd_ready.
  - After the last transfer: rd_valid=0, count=0 -> IDLE.
  - arm and rd_start are ignored in DRAIN.
- Drain delivers exactly count entries, oldest to newest.

Decomposition:
- Package riscv_trace_pkg:
  - state encoding: IDLE=0, CAPTURE=1, POST=2, FROZEN=3, DRAIN=4
  - mode constants MODE_WRAP=0, MODE_STOP_FULL=1
  - entry-width function TS_W+XLEN+ILEN
- Sub-module riscv_trace_ram: DEPTH x entry, 1 write port, 1 asynchronous read port, no reset.
- Control FSM, pointers and counters live in riscv_trace_buffer.

Test Plan:
- Common settings: DEPTH=8, DEDUP=1. "Retires" means ret_valid=1 on consecutive cycles with distinct PCs.
- Reset: hold reset=0 for 2 cycles with random inputs -> state=0, count=0, rd_valid=0, rd_data=0, trig_hit=0.
- Wrap: mode=0, arm, retire 10 PCs 0x00,0x04..0x24, drop arm, rd_start -> count=8; 8 transfers with PCs 0x08..0x24 in order and ts strictly increasing by 1; then state=IDLE.
- Stop-full: mode=1, retire the same 10 PCs -> FROZEN after the 8th (0x1C) while arm is still 1; drain yields 0x00..0x1C.
- Trigger: mode=0, trig_en=1, trig_pc=0x10, post_cnt=2, retire 0x00..0x24 -> trig_hit=1, frozen after 0x18, count=7; drain yields 0x00..0x18.
- Dedup/backpressure: pc_i=0x40 with ret_valid high for 5 cycles -> count=1. Drain with rd_ready low for 3 cycles -> rd_data constant and rd_valid high throughout; transfer occurs on the rd_ready rise.
- Reset mid-drain: assert reset=0 after the 2nd transfer of a 6-entry drain -> next cycle state=IDLE, rd_valid=0, count=0.
